m_reg: RTL and testbench
========================

M_REG -- requirements
Module: m_reg

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 E_op  input  6  opcode of the instruction leaving the Execute stage.
REQ-005 e_valE  input  32  ALU result computed in Execute.
REQ-006 E_valA  input  32  operand A carried from Execute, used as store data.
REQ-007 E_dstE  input  5  destination register for the ALU result.
REQ-008 E_dstM  input  5  destination register for the memory load result.
REQ-009 M_stall  input  1  hold the current contents.
REQ-010 M_bubble  input  1  load the NOP pattern instead of the inputs.
REQ-011 M_op  output  6  registered opcode.
REQ-012 M_valE  output  32  registered ALU result.
REQ-013 M_valA  output  32  registered operand A.
REQ-014 M_dstE  output  5  registered ALU destination.
REQ-015 M_dstM  output  5  registered load destination.
REQ-016 Port order SHALL be: M_op, M_valE, M_valA, M_dstE, M_dstM, clk, E_op, e_valE, E_valA, E_dstE, E_dstM, rst, M_stall, M_bubble, then the optional port.

Function
REQ-017 On a rising clk edge with rst=0, M_bubble=0 and M_stall=0, each M_* output SHALL take the value of its E_*/e_* input, giving one-cycle latency.
REQ-018 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-019 With M_bubble=1 at a clock edge, the register SHALL load the NOP pattern: M_op=IROP (6'b000000) and all other outputs 0, i.e. an R-type instruction writing $0.
REQ-020 With M_stall=1 and M_bubble=0 at a clock edge, all outputs SHALL hold their previous values.
REQ-021 Priority SHALL be rst > M_bubble > M_stall > normal load; when M_bubble and M_stall are both 1, the bubble SHALL win.
REQ-022 Opcode values SHALL pass through unmodified, including any code not listed in the package; no decoding is done in this block.
REQ-023 Data fields SHALL pass through bit-exact, with no sign extension or masking.

Reset
REQ-024 While rst=1, all outputs SHALL asynchronously equal the NOP pattern: M_op=000000 and M_valE, M_valA, M_dstE and M_dstM all 0.
REQ-025 When rst is released, the first rising edge with rst=0 SHALL perform a normal load, stall or bubble as commanded.
REQ-026 Asserting rst mid-stream SHALL discard the held instruction immediately, without waiting for a clock edge.

Configuration
REQ-027 With macro M_REG_VALID_EN defined, the block SHALL add an output port M_valid (1 bit) and a flop behind it.
REQ-028 M_valid SHALL be 0 on reset and on bubble, 1 after a normal load, and SHALL hold on stall.
REQ-029 Without M_REG_VALID_EN, the M_valid port and its flop SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 The opcode constants SHALL live in the shared package/header used by every pipeline stage: IROP, IANDI, IADDI, IJ, ILW, ISW, IORI, IXORI and INORI.
REQ-031 The NOP pattern constant SHALL also live in that shared package/header.
REQ-032 A single sub-module, pipe_field_reg (parameterised width, with async reset, stall, bubble and bubble-value controls), SHALL be instantiated once per field.

Verification
REQ-033 Load: rst=0, E_op=IADDI, e_valE=3, E_valA=3, E_dstE=3, E_dstM=3, then one edge -> M_op=IADDI and all other outputs 3.
REQ-034 Sequence: apply IROP/1, IANDI/2, IADDI/3, IJ/4, ILW/5, ISW/6, IORI/7, XORI/8, NORI/9 on successive edges -> outputs trail the inputs by exactly one edge.
REQ-035 Stall: load ILW with all fields 5, then M_stall=1 with inputs ISW/6 for 2 edges -> outputs stay ILW/5.
REQ-036 Bubble: load ISW/6, then M_bubble=1 -> M_op=000000 and all fields 0; with M_stall=1 and M_bubble=1 together -> the bubble result is the same.
REQ-037 Async reset: with outputs at IORI/7, pulse rst between edges -> outputs go to 0 before the next edge.
REQ-038 With M_REG_VALID_EN: M_valid goes 0 after reset, 1 after a load, holds on stall, and goes 0 after a bubble.

Source files
------------

// File: rtl/m_reg_pkg.sv
// Shared pipeline package: opcode constants, the register-stage field bundle
// and the NOP pattern that bubbles and reset load into every stage register.
package m_reg_pkg;

  localparam int OP_W  = 6;
  localparam int VAL_W = 32;
  localparam int REG_W = 5;

  // Opcodes understood by the pipeline (MIPS-style encodings).
  localparam logic [OP_W-1:0] IROP  = 6'b000000;
  localparam logic [OP_W-1:0] IJ    = 6'b000010;
  localparam logic [OP_W-1:0] IADDI = 6'b001000;
  localparam logic [OP_W-1:0] IANDI = 6'b001100;
  localparam logic [OP_W-1:0] IORI  = 6'b001101;
  localparam logic [OP_W-1:0] IXORI = 6'b001110;
  localparam logic [OP_W-1:0] INORI = 6'b010011;
  localparam logic [OP_W-1:0] ILW   = 6'b100011;
  localparam logic [OP_W-1:0] ISW   = 6'b101011;

  // Fields carried by the Execute -> Memory pipeline register.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [VAL_W-1:0] valE;
    logic [VAL_W-1:0] valA;
    logic [REG_W-1:0] dstE;
    logic [REG_W-1:0] dstM;
  } mFields_t;

  // NOP: an R-type instruction that writes register $0.
  localparam mFields_t NOP_FIELDS = '{
    op:   IROP,
    valE: '0,
    valA: '0,
    dstE: '0,
    dstM: '0
  };

endpackage

// File: rtl/m_reg_pipe_field_reg.sv
// pipe_field_reg: one field of a pipeline register. Asynchronous reset to
// RESET_VAL, bubble loads bubbleVal, stall holds, otherwise loads d.
module pipe_field_reg #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  output logic [WIDTH-1:0] q,
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             bubble,
  input  logic [WIDTH-1:0] bubbleVal,
  input  logic [WIDTH-1:0] d
);

  // Field flop: reset > bubble > stall > load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (bubble) begin
      q <= bubbleVal;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/m_reg.sv
// m_reg: Execute -> Memory pipeline register. Every output comes straight
// from a pipe_field_reg flop. Optional feature macro: M_REG_VALID_EN adds
// the M_valid output (0 on reset/bubble, 1 after a load, held on stall).
module m_reg
  import m_reg_pkg::*;
(
  output logic [OP_W-1:0]  M_op,
  output logic [VAL_W-1:0] M_valE,
  output logic [VAL_W-1:0] M_valA,
  output logic [REG_W-1:0] M_dstE,
  output logic [REG_W-1:0] M_dstM,
  input  logic             clk,
  input  logic [OP_W-1:0]  E_op,
  input  logic [VAL_W-1:0] e_valE,
  input  logic [VAL_W-1:0] E_valA,
  input  logic [REG_W-1:0] E_dstE,
  input  logic [REG_W-1:0] E_dstM,
  input  logic             rst,
  input  logic             M_stall,
  input  logic             M_bubble
`ifdef M_REG_VALID_EN
  ,
  output logic             M_valid
`endif
);

  // Opcode passes through undecoded; unknown codes are carried as-is.
  pipe_field_reg #(.WIDTH(OP_W), .RESET_VAL(NOP_FIELDS.op)) opReg (
    .q(M_op), .clk(clk), .rst(rst), .stall(M_stall), .bubble(M_bubble),
    .bubbleVal(NOP_FIELDS.op), .d(E_op)
  );

  pipe_field_reg #(.WIDTH(VAL_W), .RESET_VAL(NOP_FIELDS.valE)) valEReg (
    .q(M_valE), .clk(clk), .rst(rst), .stall(M_stall), .bubble(M_bubble),
    .bubbleVal(NOP_FIELDS.valE), .d(e_valE)
  );

  pipe_field_reg #(.WIDTH(VAL_W), .RESET_VAL(NOP_FIELDS.valA)) valAReg (
    .q(M_valA), .clk(clk), .rst(rst), .stall(M_stall), .bubble(M_bubble),
    .bubbleVal(NOP_FIELDS.valA), .d(E_valA)
  );

  pipe_field_reg #(.WIDTH(REG_W), .RESET_VAL(NOP_FIELDS.dstE)) dstEReg (
    .q(M_dstE), .clk(clk), .rst(rst), .stall(M_stall), .bubble(M_bubble),
    .bubbleVal(NOP_FIELDS.dstE), .d(E_dstE)
  );

  pipe_field_reg #(.WIDTH(REG_W), .RESET_VAL(NOP_FIELDS.dstM)) dstMReg (
    .q(M_dstM), .clk(clk), .rst(rst), .stall(M_stall), .bubble(M_bubble),
    .bubbleVal(NOP_FIELDS.dstM), .d(E_dstM)
  );

`ifdef M_REG_VALID_EN
  // Valid bit: a normal load always carries a real instruction.
  pipe_field_reg #(.WIDTH(1), .RESET_VAL(1'b0)) validReg (
    .q(M_valid), .clk(clk), .rst(rst), .stall(M_stall), .bubble(M_bubble),
    .bubbleVal(1'b0), .d(1'b1)
  );
`endif

endmodule

// File: tb/tb_m_reg.sv
// tb_m_reg: directed self-checking bench for m_reg (define M_REG_VALID_EN
// on both builds to also check M_valid).
module tb_m_reg;
  import m_reg_pkg::*;

  logic [OP_W-1:0]  M_op;
  logic [VAL_W-1:0] M_valE, M_valA;
  logic [REG_W-1:0] M_dstE, M_dstM;
  logic             clk = 1'b0;
  logic [OP_W-1:0]  E_op = '0;
  logic [VAL_W-1:0] e_valE = '0, E_valA = '0;
  logic [REG_W-1:0] E_dstE = '0, E_dstM = '0;
  logic             rst = 1'b1;
  logic             M_stall = 1'b0, M_bubble = 1'b0;
`ifdef M_REG_VALID_EN
  logic             M_valid;
`endif

  int checks = 0;
  int failures = 0;

  m_reg dut (
    .M_op(M_op), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE),
    .M_dstM(M_dstM), .clk(clk), .E_op(E_op), .e_valE(e_valE),
    .E_valA(E_valA), .E_dstE(E_dstE), .E_dstM(E_dstM), .rst(rst),
    .M_stall(M_stall), .M_bubble(M_bubble)
`ifdef M_REG_VALID_EN
    , .M_valid(M_valid)
`endif
  );

  always #5 clk = ~clk;

  // Drive all inputs: opcode plus one value replicated into every field.
  task automatic drive(input logic [OP_W-1:0] op, input logic [31:0] v);
    E_op = op; e_valE = v; E_valA = v; E_dstE = v[4:0]; E_dstM = v[4:0];
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs against expected values and print one line.
  task automatic expect_out(input string tag, input logic [OP_W-1:0] op,
                            input logic [31:0] ve, input logic [31:0] va,
                            input logic [4:0] de, input logic [4:0] dm,
                            input logic vld);
    logic [79:0] obs, exp_v;
    obs   = {M_op, M_valE, M_valA, M_dstE, M_dstM};
    exp_v = {op, ve, va, de, dm};
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
`ifdef M_REG_VALID_EN
    checks++;
    assert (M_valid === vld) else begin
      failures++;
      $error("FAIL %s_valid observed=%b expected=%b", tag, M_valid, vld);
    end
`else
    if (vld === 1'bx) $display("unexpected x on expected valid in %s", tag);
`endif
    $display("t=%0t %s op=%h valE=%h valA=%h dstE=%0d dstM=%0d", $time, tag,
             M_op, M_valE, M_valA, M_dstE, M_dstM);
  endtask

  logic [OP_W-1:0] seqOps [9];

  initial begin
    seqOps = '{IROP, IANDI, IADDI, IJ, ILW, ISW, IORI, IXORI, INORI};

    // Reset held from time 0: outputs are NOP even before any edge.
    drive(ILW, 32'd5);
    #1;
    expect_out("reset_async", IROP, 0, 0, 0, 0, 1'b0);
    tick();
    expect_out("reset_hold_edge", IROP, 0, 0, 0, 0, 1'b0);

    // Release reset between edges; first edge performs a normal load.
    rst = 1'b0;
    drive(IADDI, 32'd3);
    tick();
    expect_out("load_addi", IADDI, 3, 3, 3, 3, 1'b1);

    // Sequence: outputs trail inputs by exactly one edge.
    for (int i = 0; i < 9; i++) begin
      drive(seqOps[i], 32'(i + 1));
      tick();
      expect_out($sformatf("seq_%0d", i + 1), seqOps[i], 32'(i + 1),
                 32'(i + 1), 5'(i + 1), 5'(i + 1), 1'b1);
    end

    // Stall holds ILW/5 for two edges while ISW/6 is presented.
    drive(ILW, 32'd5);
    tick();
    expect_out("stall_load", ILW, 5, 5, 5, 5, 1'b1);
    M_stall = 1'b1;
    drive(ISW, 32'd6);
    tick();
    expect_out("stall_1", ILW, 5, 5, 5, 5, 1'b1);
    tick();
    expect_out("stall_2", ILW, 5, 5, 5, 5, 1'b1);
    M_stall = 1'b0;
    tick();
    expect_out("stall_release", ISW, 6, 6, 6, 6, 1'b1);

    // Bubble replaces the inputs with NOP.
    M_bubble = 1'b1;
    tick();
    expect_out("bubble", IROP, 0, 0, 0, 0, 1'b0);
    M_bubble = 1'b0;
    tick();
    expect_out("bubble_reload", ISW, 6, 6, 6, 6, 1'b1);

    // Bubble wins over stall.
    M_bubble = 1'b1;
    M_stall  = 1'b1;
    tick();
    expect_out("bubble_and_stall", IROP, 0, 0, 0, 0, 1'b0);
    M_bubble = 1'b0;
    tick();
    expect_out("stall_after_bubble", IROP, 0, 0, 0, 0, 1'b0);
    M_stall = 1'b0;

    // Unlisted opcode and full-width data pass through bit-exact.
    E_op = 6'b111111; e_valE = 32'hDEADBEEF; E_valA = 32'h80000001;
    E_dstE = 5'd31; E_dstM = 5'd17;
    tick();
    expect_out("passthrough", 6'b111111, 32'hDEADBEEF, 32'h80000001,
               5'd31, 5'd17, 1'b1);

    // Async reset pulse between edges clears immediately.
    drive(IORI, 32'd7);
    tick();
    expect_out("pre_reset", IORI, 7, 7, 7, 7, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    expect_out("async_reset", IROP, 0, 0, 0, 0, 1'b0);
    rst = 1'b0;
    #1;
    expect_out("after_pulse", IROP, 0, 0, 0, 0, 1'b0);
    drive(IXORI, 32'd8);
    tick();
    expect_out("load_after_reset", IXORI, 8, 8, 8, 8, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
